// File: rtl/ldpc_sched_pkg.sv
// Shared scheduler types: state encoding, default widths and the iteration-limit clip helper.
package ldpc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROW   = 3'd2,
    S_COL   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } sched_state_e;

  localparam int ITER_W_DEF    = 7;
  localparam int PHASE_TMO_DEF = 1023;

  // A limit beyond what the saturating counter can reach would never trigger.
  function automatic int clip_lim(input int lim, input int w);
    int top;
    top = (1 << w) - 1;
    return (lim > top) ? top : lim;
  endfunction

endpackage

// File: rtl/ldpc_iter_sched_if.sv
// Scheduler <-> frame source / alpha-beta engines: strobes in, phase pulses and status out.
// master drives the i_* side (datapath/source), slave is the scheduler.
interface ldpc_iter_sched_if
  import ldpc_sched_pkg::*;
#(
  parameter int M      = 4,
  parameter int ITER_W = ITER_W_DEF
);
  logic              i_val;
  logic [ITER_W-1:0] i_max_iter;
  logic              i_row_done;
  logic              i_col_done;
  logic [M-1:0]      i_syndrome;
  logic              o_ready;
  logic              o_load;
  logic              o_row_start;
  logic              o_col_start;
  logic [ITER_W-1:0] o_iter;
  logic              o_val;
  logic              o_success;
  logic              o_timeout;
  logic              o_err;

  modport master (
    output i_val, i_max_iter, i_row_done, i_col_done, i_syndrome,
    input  o_ready, o_load, o_row_start, o_col_start, o_iter, o_val, o_success, o_timeout, o_err
  );

  modport slave (
    input  i_val, i_max_iter, i_row_done, i_col_done, i_syndrome,
    output o_ready, o_load, o_row_start, o_col_start, o_iter, o_val, o_success, o_timeout, o_err
  );
endinterface

// File: rtl/ldpc_phase_wdt.sv
// Phase watchdog: clearable up-counter, expire flag is registered-derived (cnt == PHASE_TMO).
// Counting stops at expiry; clear has priority over enable.
module ldpc_phase_wdt
  import ldpc_sched_pkg::*;
#(
  parameter int PHASE_TMO = PHASE_TMO_DEF
) (
  input  logic clk,
  input  logic xrst,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);
  localparam int            CW  = $clog2(PHASE_TMO + 1);
  localparam logic [CW-1:0] TMO = CW'(PHASE_TMO);

  logic [CW-1:0] cnt_q, cnt_d;

  assign exp_o = (cnt_q == TMO);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !exp_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ldpc_iter_sched.sv
// LDPC min-sum iteration scheduler: LOAD -> (ROW -> COL -> CHECK)* -> DONE, all outputs from flops.
// i_val accepted only in IDLE; engine done pulses gate phase progress, watchdog aborts a stuck phase.
module ldpc_iter_sched
  import ldpc_sched_pkg::*;
#(
  parameter int M         = 4,
  parameter int ITER_W    = ITER_W_DEF,
  parameter int MAX_ITER  = 100,
  parameter int PHASE_TMO = PHASE_TMO_DEF
) (
  input logic              clk,
  input logic              xrst,
  ldpc_iter_sched_if.slave sif
);
  localparam logic [ITER_W-1:0] LIM_DEF = ITER_W'(clip_lim(MAX_ITER, ITER_W));
  localparam logic [M-1:0]      SYN_OK  = '0;

  sched_state_e      state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d, lim_q, lim_d, iter_inc;
  logic              succ_q, succ_d, tmo_q, tmo_d, err_q, err_d;
  logic              start_q, phase_clr, wdt_exp;

  assign iter_inc = (&iter_q) ? iter_q : iter_q + 1'b1;

  ldpc_phase_wdt #(.PHASE_TMO(PHASE_TMO)) u_wdt (
    .clk   (clk),
    .xrst  (xrst),
    .clr_i (phase_clr),
    .en_i  ((state_q == S_ROW) || (state_q == S_COL)),
    .exp_o (wdt_exp)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    lim_d     = lim_q;
    succ_d    = succ_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    phase_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sif.i_val) begin
          lim_d   = (sif.i_max_iter == '0) ? LIM_DEF : sif.i_max_iter;
          iter_d  = '0;
          succ_d  = 1'b0;
          tmo_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d   = S_ROW;
        phase_clr = 1'b1;
      end
      // A done pulse coinciding with the start pulse belongs to a previous pass.
      S_ROW: begin
        if (wdt_exp) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!start_q && sif.i_row_done) begin
          state_d   = S_COL;
          phase_clr = 1'b1;
        end
      end
      S_COL: begin
        if (wdt_exp) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!start_q && sif.i_col_done) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        iter_d = iter_inc;
        if (sif.i_syndrome == SYN_OK) begin
          succ_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_inc == lim_q) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d   = S_ROW;
          phase_clr = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Entering COL from ROW also clears the watchdog and marks a start cycle.
    if (state_q == S_ROW && state_d == S_COL) phase_clr = 1'b1;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      lim_q   <= '0;
      succ_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      lim_q   <= lim_d;
      succ_q  <= succ_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      start_q <= phase_clr;
    end
  end

  assign sif.o_ready     = (state_q == S_IDLE);
  assign sif.o_load      = (state_q == S_LOAD);
  assign sif.o_row_start = (state_q == S_ROW) && start_q;
  assign sif.o_col_start = (state_q == S_COL) && start_q;
  assign sif.o_val       = (state_q == S_DONE);
  assign sif.o_iter      = iter_q;
  assign sif.o_success   = succ_q;
  assign sif.o_timeout   = tmo_q;
  assign sif.o_err       = err_q;
endmodule
